// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the FIFO read-side stream adapter.
package fifo_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Credit scheme needs room for a full pipeline plus a landed word and a held head.
    function automatic bit bufDepthOk(input int depth, input int lat);
        return (depth >= lat + 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundle between the FIFO read port, the consumer stream and debug taps.
// Optional outBeatCount is present only when FIFO_RD_STATS_EN is defined.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
);
    logic                          fifoEmpty;
    logic [DATA_WIDTH-1:0]         fifoRdData;
    logic                          fifoRdEn;
    logic                          flush;
    // Stream handshake: a word transfers in every cycle where outValid && outReady;
    // outData is held stable while outValid is high and outReady is low.
    logic                          outReady;
    logic                          outValid;
    logic [DATA_WIDTH-1:0]         outData;
    logic                          busy;
    logic [0:0]                    dbgState;
    logic [ptrWidth(BUF_DEPTH):0]  dbgOcc;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]                   outBeatCount;
`endif

    modport master (
        input  fifoEmpty, fifoRdData, flush, outReady,
`ifdef FIFO_RD_STATS_EN
        output outBeatCount,
`endif
        output fifoRdEn, outValid, outData, busy, dbgState, dbgOcc
    );

    modport slave (
        output fifoEmpty, fifoRdData, flush, outReady,
`ifdef FIFO_RD_STATS_EN
        input  outBeatCount,
`endif
        input  fifoRdEn, outValid, outData, busy, dbgState, dbgOcc
    );

endinterface

// File: rtl/rd_land_buf.sv
// Landing ring buffer: words from the FIFO read pipe are pushed here and popped by the stream.
module rd_land_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          clear,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         pushData,
    input  logic                          pop,
    output logic [ptrWidth(BUF_DEPTH):0]  occ,
    output logic [DATA_WIDTH-1:0]         headData
);
    localparam int PW = ptrWidth(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wrPtr;
    logic [PW-1:0]         rdPtr;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clear) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers are exactly log2(BUF_DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk) begin
        if (!resetN || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign headData = mem[rdPtr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: speculative FIFO reads with credit control, landing buffer and flush FSM.
// Define FIFO_RD_STATS_EN to add the 16-bit pop counter outBeatCount.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           resetN,
    fifo_rd_stream_if.master bus
);
    localparam int CW = ptrWidth(BUF_DEPTH) + 1;
    localparam logic [0:0] ST_RUN   = RUN;
    localparam logic [0:0] ST_FLUSH = FLUSH;

    if (!bufDepthOk(BUF_DEPTH, RD_LATENCY)) begin : gBadCfg
        $error("BUF_DEPTH must be a power of two and >= RD_LATENCY+2");
    end

    logic [0:0]            state;
    logic [RD_LATENCY-1:0] inflightSr;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         occ;
    logic                  running;
    logic                  issue;
    logic                  land;
    logic                  pop;
    logic                  clear;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(inflightSr[i]);
        end
    end

    assign running = (state == ST_RUN);

    // Credit counts every word already read but not yet popped, so a landing word always has a slot.
    assign bus.fifoRdEn = resetN && running && !bus.flush && !bus.fifoEmpty
                          && ((occ + inflight) < CW'(BUF_DEPTH));
    assign issue        = bus.fifoRdEn && !bus.fifoEmpty;
    assign land         = inflightSr[RD_LATENCY-1] && running && !bus.flush;
    assign clear        = running && bus.flush;
    assign bus.outValid = running && (occ != '0);
    assign pop          = bus.outValid && bus.outReady;
    assign bus.busy     = (state == ST_FLUSH);
    assign bus.dbgState = state;
    assign bus.dbgOcc   = occ;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= ST_RUN;
            inflightSr <= '0;
        end else begin
            inflightSr <= (inflightSr << 1) | RD_LATENCY'(issue);
            case (state)
                ST_RUN:   if (bus.flush) state <= ST_FLUSH;
                ST_FLUSH: if (inflightSr == '0) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    rd_land_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) uLandBuf (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (clear),
        .push     (land),
        .pushData (bus.fifoRdData),
        .pop      (pop),
        .occ      (occ),
        .headData (bus.outData)
    );

`ifdef FIFO_RD_STATS_EN
    // Survives flush on purpose: it counts delivered beats, not buffer lifetime.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            bus.outBeatCount <= '0;
        end else if (pop) begin
            bus.outBeatCount <= bus.outBeatCount + 16'd1;
        end
    end
`endif

endmodule
